// File: rtl/alu_issue_if.sv
// Bus bundle for alu_issue: instruction handshake, host preload/read, ALU drive and result ports.
// res_zero exists only when ALU_ISSUE_ZERO_FLAG_EN is defined.
interface alu_issue_if;
   // Handshake: an instruction transfers on a rising edge where instr_valid and
   // instr_ready are both high; the source holds its fields stable until then.
   logic       instr_valid;
   logic       instr_ready;
   logic [2:0] instr_op;
   logic [1:0] instr_dst;
   logic [1:0] instr_srca;
   logic [1:0] instr_srcb;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic [1:0] rd_addr;
   logic [7:0] rd_data;
   logic [7:0] alu_a1;
   logic [7:0] alu_a2;
   logic [5:0] alu_opflag;
   logic       alu_eflag;
   logic       alu_cin;
   logic [7:0] alu_out;
   logic       alu_cout;
   logic       res_valid;
   logic [7:0] res_data;
   logic       res_carry;
   logic [1:0] res_dst;
   logic [1:0] dbg_state;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
   logic       res_zero;
`endif

   modport slave (
      input  instr_valid, instr_op, instr_dst, instr_srca, instr_srcb,
      input  wr_en, wr_addr, wr_data, rd_addr, alu_out, alu_cout,
      output instr_ready, rd_data, alu_a1, alu_a2, alu_opflag, alu_eflag, alu_cin,
      output res_valid, res_data, res_carry, res_dst, dbg_state
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      , output res_zero
`endif
   );

   modport master (
      output instr_valid, instr_op, instr_dst, instr_srca, instr_srcb,
      output wr_en, wr_addr, wr_data, rd_addr, alu_out, alu_cout,
      input  instr_ready, rd_data, alu_a1, alu_a2, alu_opflag, alu_eflag, alu_cin,
      input  res_valid, res_data, res_carry, res_dst, dbg_state
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      , input res_zero
`endif
   );
endinterface

// File: rtl/alu_issue.sv
// Sequencing front end for the 8-bit combinational ALU: 4x8 register file, carry flag, IDLE/ISSUE/WB FSM.
// Optional zero flag (res_zero) enabled by defining ALU_ISSUE_ZERO_FLAG_EN.
module alu_issue #(
   parameter int REGS = 4
) (
   input logic   clk,
   input logic   rst,
   alu_issue_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WB = 2'd2} state_t;

   state_t     state, next_state;
   logic [7:0] regs [REGS];
   logic       carry;
   logic       ready;
   logic       accept;
   logic       arith;
   logic [1:0] dst;
   logic [7:0] a1, a2, res_data;
   logic [5:0] opflag;
   logic       cin, res_valid;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
   logic       zero;
`endif

   function automatic logic [5:0] decode_op(input logic [2:0] op);
      case (op)
         3'd0:       decode_op = 6'b000001;
         3'd1:       decode_op = 6'b000010;
         3'd2:       decode_op = 6'b000100;
         3'd3, 3'd6: decode_op = 6'b001000;
         3'd4, 3'd7: decode_op = 6'b010000;
         default:    decode_op = 6'b100000;
      endcase
   endfunction

   assign accept = bus.instr_valid & ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = ISSUE;
         ISSUE:   next_state = WB;
         WB:      next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ready is registered so it first rises on the edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready     <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         carry     <= 1'b0;
         arith     <= 1'b0;
         dst       <= '0;
         a1        <= '0;
         a2        <= '0;
         opflag    <= '0;
         cin       <= 1'b0;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
         zero      <= 1'b0;
`endif
         for (int i = 0; i < REGS; i++) regs[i] <= '0;
      end else begin
         ready     <= (next_state == IDLE);
         res_valid <= (state == ISSUE);
         if (accept) begin
            a1     <= regs[bus.instr_srca];
            a2     <= regs[bus.instr_srcb];
            opflag <= decode_op(bus.instr_op);
            cin    <= (bus.instr_op == 3'd6 || bus.instr_op == 3'd7) ? carry : 1'b0;
            arith  <= (bus.instr_op == 3'd3 || bus.instr_op == 3'd4 ||
                       bus.instr_op == 3'd6 || bus.instr_op == 3'd7);
            dst    <= bus.instr_dst;
         end else if (state == WB) begin
            opflag <= '0;
         end
         if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
         // Writeback is ordered after the host write so it wins on an address collision.
         if (state == ISSUE) begin
            regs[dst] <= bus.alu_out;
            res_data  <= bus.alu_out;
            if (arith) carry <= bus.alu_cout;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            zero      <= (bus.alu_out == 8'd0);
`endif
         end
      end
   end

   assign bus.instr_ready = ready;
   assign bus.rd_data     = regs[bus.rd_addr];
   assign bus.alu_a1      = a1;
   assign bus.alu_a2      = a2;
   assign bus.alu_opflag  = opflag;
   assign bus.alu_eflag   = (state == ISSUE);
   assign bus.alu_cin     = cin;
   assign bus.res_valid   = res_valid;
   assign bus.res_data    = res_data;
   assign bus.res_carry   = carry;
   assign bus.res_dst     = dst;
   assign bus.dbg_state   = state;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
   assign bus.res_zero    = zero;
`endif
endmodule

// File: doc/alu_issue.md
# alu_issue

Sequencing front end that drives the 8-bit ALU. It accepts register-to-register instructions over a valid/ready handshake and holds a 4×8-bit register file plus a carry flag. For each instruction it drives the ALU's one-hot operation flag, operands, enable and carry-in, then captures the result and carry-out and writes them back. It sits between the instruction source (decoder or testbench host) and the combinational ALU datapath, and provides a host preload port and a read port.

## Interface
- `REGS`, default 4: number of 8-bit registers. Fixed at 4; address width 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: an instruction is presented.
- `instr_ready` out 1: the block can accept an instruction.
- `instr_op` in 3: operation code. 0 NOT, 1 OR, 2 AND, 3 ADD, 4 SUB, 5 XOR, 6 ADDC, 7 SUBC.
- `instr_dst`, `instr_srca`, `instr_srcb` in 2 each: destination and source register addresses.
- `wr_en` in 1, `wr_addr` in 2, `wr_data` in 8: host register preload.
- `rd_addr` in 2, `rd_data` out 8: combinational register read.
- `alu_a1`, `alu_a2` out 8: ALU operands.
- `alu_opflag` out 6: one-hot operation flag. NOT 000001, OR 000010, AND 000100, ADD 001000, SUB 010000, XOR 100000.
- `alu_eflag` out 1: ALU compute enable.
- `alu_cin` out 1: ALU carry-in.
- `alu_out` in 8, `alu_cout` in 1: ALU result and carry/borrow out.
- `res_valid` out 1: one-cycle pulse when a result is written back.
- `res_data` out 8, `res_carry` out 1, `res_dst` out 2: the written-back result, the carry flag value and the destination address.

## Operation
- State machine with three states: IDLE, ISSUE, WB.
  - IDLE → ISSUE on `instr_valid & instr_ready`.
  - ISSUE → WB unconditionally.
  - WB → IDLE unconditionally.
- `instr_ready` = 1 only in IDLE (and not in reset).
- On accept, the block registers:
  - `alu_a1` = reg[srca], `alu_a2` = reg[srcb], using pre-edge register values.
  - `alu_opflag` from `instr_op`. ADDC maps to ADD; SUBC maps to SUB.
  - `alu_cin` = carry flag for ADDC/SUBC, otherwise 0.
  - `dst`.
- In ISSUE:
  - `alu_eflag` = 1. In all other states it is 0.
  - Operands and opflag are held stable.
- At the end of ISSUE:
  - `alu_out` is written to reg[dst] and to `res_data`.
  - ADD/SUB/ADDC/SUBC: carry flag ← `alu_cout`. For SUB/SUBC, `alu_cout` is the borrow.
  - NOT/OR/AND/XOR: carry flag is unchanged.
- In WB: `res_valid` = 1, `res_carry` = updated carry flag, `res_dst` = dst.
- After WB, `alu_opflag` returns to 0. `alu_a1`, `alu_a2` and `alu_cin` hold their last values.
- NOT ignores `srcb`. The operand is still read; no other effect.
- Arithmetic is modulo 256: ADD = a1+a2+cin; SUB = a1−a2−cin.
- Host write: `wr_en` writes reg[wr_addr] in any state.
  - If it collides with the writeback edge at the same address, the writeback wins and the host write is dropped.
  - A host write to a source register on the accept edge does not affect the latched operand.
- `rd_data` shows the register contents combinationally and reflects writes the cycle after the edge.

## Timing
- Accept edge E0. ISSUE during the cycle E0→E1. Writeback at E1. `res_valid` high during E1→E2. `instr_ready` high again after E2.
- Latency from accept to `res_valid` is 1 cycle. Throughput is 1 instruction per 3 cycles.
- `instr_valid` held while busy is not accepted. The instruction source must hold its fields stable until accept.
- Reset asserted, immediately and at any point including mid-ISSUE or mid-WB:
  - State → IDLE.
  - All registers, the carry flag and every output go to 0: `instr_ready`, `res_*`, `alu_*`, `rd_data` content.
  - An in-flight instruction is discarded with no `res_valid`.
- `instr_ready` = 1 from the first clock edge after reset deassertion.

## Configuration
- `ALU_ISSUE_ZERO_FLAG_EN` defined:
  - Adds output `res_zero` (1 bit) and a zero-flag register.
  - At every writeback, zero ← (`alu_out` == 0), for all operations.
  - `res_zero` shows the zero flag and is valid in WB. Reset value 0.
- Not defined: no `res_zero` port and no zero-flag logic. All other behaviour is identical.

## Test plan
- Preload r0=0x05, r1=0x03; ADD dst r2 → during ISSUE `alu_opflag`=001000 and `alu_eflag`=1. Then `res_valid` pulses for exactly 1 cycle with `res_data`=0x08, `res_carry`=0, and `rd_data`(r2)=0x08.
- r0=0xFF, r1=0x01: ADD → 0x00, carry 1. Then ADDC of r3=0 + r3=0 → `alu_cin`=1, result 0x01, carry 0.
- r0=0x03, r1=0x05: SUB → 0xFE, carry 1. Then AND 0xF0 & 0x3C → 0x30, carry stays 1.
- NOT with r0=0x0F → `alu_opflag`=000001, result 0xF0. With `ALU_ISSUE_ZERO_FLAG_EN` defined, NOT of 0xFF gives `res_zero`=1.
- Assert `rst` mid-ISSUE → all outputs 0 without waiting for a clock edge, no `res_valid`, all registers read 0 after release.
- Hold `instr_valid` continuously → accepts only every 3rd cycle. A host write to `dst` on the writeback edge leaves the ALU result in the register.
